// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, DDRAM row bases and FSM state types for lcd_char_ctrl.
// Honours LCD_4BIT_EN to select the nibble-mode init sequence.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_8B = 8'h38;
  localparam logic [7:0] FUNC_SET_4B = 8'h28;
  localparam logic [7:0] DISP_ON     = 8'h0C;
  localparam logic [7:0] ENTRY_INC   = 8'h06;
  localparam logic [7:0] CLEAR       = 8'h01;
  localparam logic [7:0] SET_DDRAM   = 8'h80;
  localparam logic [7:0] WAKE_4B_A   = 8'h33;
  localparam logic [7:0] WAKE_4B_B   = 8'h32;

`ifdef LCD_4BIT_EN
  localparam int INIT_LEN = 6;
`else
  localparam int INIT_LEN = 4;
`endif

  typedef enum logic [1:0] {
    ST_POWERUP,
    ST_INIT,
    ST_SET_ADDR,
    ST_WR_CHAR
  } lcd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SETUP,
    TX_EHIGH,
    TX_WAIT
  } tx_state_t;

  function automatic logic [7:0] rowBase(input logic [1:0] row);
    case (row)
      2'd0:    rowBase = 8'h00;
      2'd1:    rowBase = 8'h40;
      2'd2:    rowBase = 8'h14;
      default: rowBase = 8'h54;
    endcase
  endfunction

  // The clear command is always last so the long wait can key off the final index.
  function automatic logic [7:0] initCmd(input logic [2:0] idx);
`ifdef LCD_4BIT_EN
    case (idx)
      3'd0:    initCmd = WAKE_4B_A;
      3'd1:    initCmd = WAKE_4B_B;
      3'd2:    initCmd = FUNC_SET_4B;
      3'd3:    initCmd = DISP_ON;
      3'd4:    initCmd = ENTRY_INC;
      default: initCmd = CLEAR;
    endcase
`else
    case (idx)
      3'd0:    initCmd = FUNC_SET_8B;
      3'd1:    initCmd = DISP_ON;
      3'd2:    initCmd = ENTRY_INC;
      default: initCmd = CLEAR;
    endcase
`endif
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// lcd_byte_tx: one LCD bus transfer (setup, enable pulse, settle wait) with start/done handshake.
// With LCD_4BIT_EN each byte goes out as two nibble transfers on data[7:4].
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int E_CYCLES        = 50,
  parameter int CMD_WAIT_CYCLES = 5_000,
  parameter int CLR_WAIT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_byte,
  input  logic       i_long_wait,
  output logic       o_done,
  output logic       o_lcd_e,
  output logic       o_lcd_rs,
  output logic [7:0] o_data
);

  tx_state_t   r_state;
  logic [31:0] r_cnt;
  logic        r_e;
  logic        r_rs;
  logic [7:0]  r_data;
  logic        r_long;
  logic        r_done;
  logic        w_lastNib;
  logic [31:0] w_waitLast;

`ifdef LCD_4BIT_EN
  logic [3:0]  r_lowByte;
  logic        r_lowNib;
  assign w_lastNib = r_lowNib;
`else
  assign w_lastNib = 1'b1;
`endif

  // Only the final transfer of a byte gets the long clear wait.
  assign w_waitLast = (r_long && w_lastNib) ? 32'(CLR_WAIT_CYCLES - 1)
                                            : 32'(CMD_WAIT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_long  <= 1'b0;
      r_done  <= 1'b0;
`ifdef LCD_4BIT_EN
      r_lowByte <= 4'h0;
      r_lowNib  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (i_start) begin
            r_rs    <= i_rs;
            r_long  <= i_long_wait;
            r_cnt   <= '0;
            r_state <= TX_SETUP;
`ifdef LCD_4BIT_EN
            r_lowByte <= i_byte[3:0];
            r_lowNib  <= 1'b0;
            r_data    <= {i_byte[7:4], 4'h0};
`else
            r_data <= i_byte;
`endif
          end
        end
        TX_SETUP: begin
          r_e     <= 1'b1;
          r_cnt   <= '0;
          r_state <= TX_EHIGH;
        end
        TX_EHIGH: begin
          if (r_cnt == 32'(E_CYCLES - 1)) begin
            r_e     <= 1'b0;
            r_cnt   <= '0;
            r_state <= TX_WAIT;
            r_done  <= w_lastNib && (w_waitLast == 32'd0);
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        TX_WAIT: begin
          if (r_cnt == w_waitLast) begin
            r_cnt <= '0;
`ifdef LCD_4BIT_EN
            if (!r_lowNib) begin
              r_lowNib <= 1'b1;
              r_data   <= {r_lowByte, 4'h0};
              r_state  <= TX_SETUP;
            end else begin
              r_state <= TX_IDLE;
            end
`else
            r_state <= TX_IDLE;
`endif
          end else begin
            r_cnt  <= r_cnt + 32'd1;
            r_done <= w_lastNib && ((r_cnt + 32'd1) == w_waitLast);
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  assign o_done   = r_done;
  assign o_lcd_e  = r_e;
  assign o_lcd_rs = r_rs;
  assign o_data   = r_data;

endmodule

// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: initialises an HD44780-style LCD, then refreshes it forever from a ROWS x COLS buffer.
// Define LCD_4BIT_EN to run the panel in 4-bit nibble mode.
module lcd_char_ctrl
  import lcd_pkg::*;
#(
  parameter int COLS            = 16,
  parameter int ROWS            = 2,
  parameter int POWERUP_CYCLES  = 2_000_000,
  parameter int E_CYCLES        = 50,
  parameter int CMD_WAIT_CYCLES = 5_000,
  parameter int CLR_WAIT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [4:0] wr_col,
  input  logic [7:0] wr_char,
  output logic       init_done,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] data
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  lcd_state_t       r_state;
  logic [31:0]      r_cnt;
  logic [2:0]       r_initIdx;
  logic [1:0]       r_row;
  logic [4:0]       r_col;
  logic             r_start;
  logic             r_initDone;
  logic [7:0]       r_buf [CELLS];

  logic             w_done;
  logic [7:0]       w_txByte;
  logic             w_txRs;
  logic             w_txLong;
  logic             w_wrOk;
  logic [IDX_W-1:0] w_wrIdx;
  logic [IDX_W-1:0] w_rdIdx;

  assign w_wrOk  = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign w_wrIdx = IDX_W'(int'(wr_row) * COLS + int'(wr_col));
  assign w_rdIdx = IDX_W'(int'(r_row) * COLS + int'(r_col));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) r_buf[i] <= 8'h20;
    end else if (w_wrOk) begin
      r_buf[w_wrIdx] <= wr_char;
    end
  end

  // The byte is captured by the transmitter as it enters setup, so it reflects the buffer then.
  always_comb begin
    w_txByte = 8'h00;
    w_txRs   = 1'b0;
    w_txLong = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_txByte = initCmd(r_initIdx);
        w_txLong = (r_initIdx == 3'(INIT_LEN - 1));
      end
      ST_SET_ADDR: w_txByte = SET_DDRAM | rowBase(r_row);
      ST_WR_CHAR: begin
        w_txByte = r_buf[w_rdIdx];
        w_txRs   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_POWERUP;
      r_cnt      <= '0;
      r_initIdx  <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_start    <= 1'b0;
      r_initDone <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_POWERUP: begin
          if (r_cnt == 32'(POWERUP_CYCLES - 1)) begin
            r_cnt     <= '0;
            r_initIdx <= '0;
            r_state   <= ST_INIT;
            r_start   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_INIT: begin
          if (w_done) begin
            r_start <= 1'b1;
            if (r_initIdx == 3'(INIT_LEN - 1)) begin
              r_initDone <= 1'b1;
              r_row      <= '0;
              r_state    <= ST_SET_ADDR;
            end else begin
              r_initIdx <= r_initIdx + 3'd1;
            end
          end
        end
        ST_SET_ADDR: begin
          if (w_done) begin
            r_col   <= '0;
            r_state <= ST_WR_CHAR;
            r_start <= 1'b1;
          end
        end
        ST_WR_CHAR: begin
          if (w_done) begin
            r_start <= 1'b1;
            if (r_col == 5'(COLS - 1)) begin
              r_row   <= (r_row == 2'(ROWS - 1)) ? 2'd0 : r_row + 2'd1;
              r_state <= ST_SET_ADDR;
            end else begin
              r_col <= r_col + 5'd1;
            end
          end
        end
        default: r_state <= ST_POWERUP;
      endcase
    end
  end

  lcd_byte_tx #(
    .E_CYCLES        (E_CYCLES),
    .CMD_WAIT_CYCLES (CMD_WAIT_CYCLES),
    .CLR_WAIT_CYCLES (CLR_WAIT_CYCLES)
  ) u_tx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (r_start),
    .i_rs        (w_txRs),
    .i_byte      (w_txByte),
    .i_long_wait (w_txLong),
    .o_done      (w_done),
    .o_lcd_e     (lcd_e),
    .o_lcd_rs    (lcd_rs),
    .o_data      (data)
  );

  assign init_done = r_initDone;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb_lcd_char_ctrl: randomized self-checking bench; expected LCD traffic comes from a screen-cell model.
// Define LCD_4BIT_EN to check nibble-mode traffic.
module tb_lcd_char_ctrl;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int PWR  = 20;
  localparam int ECYC = 3;
  localparam int CMDW = 5;
  localparam int CLRW = 12;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [1:0] wr_row  = 2'd0;
  logic [4:0] wr_col  = 5'd0;
  logic [7:0] wr_char = 8'h00;
  logic       init_done;
  logic       lcd_rw;
  logic       lcd_e;
  logic       lcd_rs;
  logic [7:0] lcd_data;

  int checkCount = 0;
  int passCount  = 0;

  logic [8:0] capQ[$];
  logic [8:0] expQ[$];
  logic [7:0] model [ROWS][COLS];
  logic [7:0] baseTab [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  int         sinceRst    = 0;
  int         firstRiseAt = -1;
  int         highLen     = 0;
  logic       prevE       = 1'b0;
  logic       stableOk    = 1'b1;
  logic [8:0] highVal     = '0;

  always #5 clk = ~clk;

  lcd_char_ctrl #(
    .COLS            (COLS),
    .ROWS            (ROWS),
    .POWERUP_CYCLES  (PWR),
    .E_CYCLES        (ECYC),
    .CMD_WAIT_CYCLES (CMDW),
    .CLR_WAIT_CYCLES (CLRW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_char   (wr_char),
    .init_done (init_done),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .data      (lcd_data)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Bus monitor: records every enable pulse and checks its width and rs/data stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      sinceRst    = 0;
      firstRiseAt = -1;
      prevE       = 1'b0;
      highLen     = 0;
    end else begin
      sinceRst++;
      if (lcd_e && !prevE) begin
        highVal  = {lcd_rs, lcd_data};
        highLen  = 1;
        stableOk = 1'b1;
        capQ.push_back(highVal);
        if (firstRiseAt < 0) firstRiseAt = sinceRst;
`ifdef LCD_4BIT_EN
        checkOutput("lowNibbleZero", 32'(lcd_data[3:0]), 32'd0);
`endif
      end else if (lcd_e) begin
        highLen++;
        if ({lcd_rs, lcd_data} !== highVal) stableOk = 1'b0;
      end else if (prevE) begin
        if ({lcd_rs, lcd_data} !== highVal) stableOk = 1'b0;
        checkOutput("eHighLen", 32'(highLen), 32'(ECYC));
        checkOutput("xferStable", 32'(stableOk), 32'd1);
      end
      prevE = lcd_e;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic resetModel();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 8'h20;
  endtask

  task automatic applyStimulus(input int row, input int col, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_row  = 2'(row);
    wr_col  = 5'(col);
    wr_char = ch;
    nextCycle();
    wr_en = 1'b0;
    if (row < ROWS && col < COLS) model[row][col] = ch;
  endtask

  task automatic pushExpected(input logic rs, input logic [7:0] b);
`ifdef LCD_4BIT_EN
    expQ.push_back({rs, b[7:4], 4'h0});
    expQ.push_back({rs, b[3:0], 4'h0});
`else
    expQ.push_back({rs, b});
`endif
  endtask

  task automatic expectInit();
`ifdef LCD_4BIT_EN
    pushExpected(1'b0, 8'h33);
    pushExpected(1'b0, 8'h32);
    pushExpected(1'b0, 8'h28);
`else
    pushExpected(1'b0, 8'h38);
`endif
    pushExpected(1'b0, 8'h0C);
    pushExpected(1'b0, 8'h06);
    pushExpected(1'b0, 8'h01);
  endtask

  task automatic expectPass();
    for (int r = 0; r < ROWS; r++) begin
      pushExpected(1'b0, 8'h80 | baseTab[r]);
      for (int c = 0; c < COLS; c++) pushExpected(1'b1, model[r][c]);
    end
  endtask

  task automatic getXfer(output logic [8:0] x);
    int waited = 0;
    while (capQ.size() == 0 && waited < 300) begin
      nextCycle();
      waited++;
    end
    checkOutput("xferArrived", 32'(capQ.size() > 0), 32'd1);
    if (capQ.size() > 0) x = capQ.pop_front();
    else x = '1;
  endtask

  task automatic checkStream(input string tag);
    logic [8:0] x;
    logic [8:0] e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      getXfer(x);
      checkOutput(tag, 32'(x), 32'(e));
    end
  endtask

  task automatic runInit();
    int n;
    expectInit();
    checkStream("initCmd");
    checkOutput("powerupIdle", 32'((firstRiseAt - 1 >= PWR + 1) && (firstRiseAt - 1 <= PWR + 3)), 32'd1);
    checkOutput("initDoneBeforeClearWait", 32'(init_done), 32'd0);
    n = 0;
    while (lcd_e && n < 50) begin
      nextCycle();
      n++;
    end
    n = 1;
    while (!init_done && n < 100) begin
      nextCycle();
      n++;
    end
    checkOutput("initDoneDelay", 32'(n), 32'(CLRW + 1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8:0] x;
    logic [8:0] thirdExp;

    nextCycle();
    nextCycle();
    checkOutput("rstE", 32'(lcd_e), 32'd0);
    checkOutput("rstRs", 32'(lcd_rs), 32'd0);
    checkOutput("rstRw", 32'(lcd_rw), 32'd0);
    checkOutput("rstData", 32'(lcd_data), 32'd0);
    checkOutput("rstInitDone", 32'(init_done), 32'd0);

    resetModel();
    capQ.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        applyStimulus(2 + int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 8'($urandom));
      else
        applyStimulus(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(COLS, 31)), 8'($urandom));
    end
    runInit();
    expectPass();
    expectPass();
    checkStream("refreshBlank");
    checkOutput("initDoneHeld", 32'(init_done), 32'd1);

    pushExpected(1'b0, 8'h80);
    pushExpected(1'b1, model[0][0]);
    pushExpected(1'b1, model[0][1]);
    checkStream("refreshHead");
    pushExpected(1'b1, model[0][2]);
    thirdExp = expQ.pop_front();
    expQ.delete();
    getXfer(x);
    checkOutput("thirdByte", 32'(x), 32'(thirdExp));
    checkOutput("eHighBeforeReset", 32'(lcd_e), 32'd1);
    rst_n = 1'b0;
    nextCycle();
    checkOutput("midRstE", 32'(lcd_e), 32'd0);
    checkOutput("midRstData", 32'(lcd_data), 32'd0);
    checkOutput("midRstRs", 32'(lcd_rs), 32'd0);
    checkOutput("midRstInitDone", 32'(init_done), 32'd0);
    nextCycle();
    nextCycle();
    capQ.delete();
    resetModel();
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 8'($urandom_range(33, 126)));
    applyStimulus(1, 2, 8'h41);
    checkOutput("initDoneLowAfterRst", 32'(init_done), 32'd0);
    runInit();
    expectPass();
    expectPass();
    checkStream("refreshModel");
    checkOutput("rwLow", 32'(lcd_rw), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
